// File: rtl/vending_fsm_multi_if.sv
// Vending machine bus interface.
// Groups the customer-side request signals (coin, selection, cancel) and the
// machine-side responses (credit, dispense, change, status pulses).
//   master : drives coin_valid/coin/sel_valid/sel/cancel, observes responses
//   slave  : the vending controller; observes requests, drives responses
interface vending_fsm_multi_if #(
    parameter int unsigned N_ITEMS = 4,
    parameter int unsigned PRICE_W = 8
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    // Requests
    logic               coin_valid;
    logic [1:0]         coin;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               cancel;

    // Responses
    logic [PRICE_W-1:0] credit;
    logic               vend_valid;
    logic [SEL_W-1:0]   vend_item;
    logic               change_valid;
    logic [1:0]         change_coin;
    logic               coin_reject;
    logic               insufficient;
    logic               busy;

    modport master (
        output coin_valid, coin, sel_valid, sel, cancel,
        input  credit, vend_valid, vend_item, change_valid, change_coin,
               coin_reject, insufficient, busy
    );

    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel,
        output credit, vend_valid, vend_item, change_valid, change_coin,
               coin_reject, insufficient, busy
    );
endinterface

// File: rtl/vending_fsm_multi.sv
// Multi-item vending controller.
// Accepts 5/10/20 rupee coins up to a credit ceiling, dispenses a selected
// item when credit covers its price, and pays out remaining credit as 10/5
// rupee coins (one per cycle) after a vend, a cancel, or an idle timeout.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - vending_fsm_multi_if.slave:
//          coin_valid/coin, sel_valid/sel, cancel          (inputs)
//          credit, vend_valid/vend_item, change_valid/change_coin,
//          coin_reject, insufficient, busy                 (registered outputs)
module vending_fsm_multi #(
    parameter int unsigned N_ITEMS = 4,
    parameter int unsigned PRICE_W = 8,
    parameter logic [N_ITEMS*PRICE_W-1:0] ITEM_PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
    parameter int unsigned MAX_CREDIT = 50,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic clk,
    input logic rst,
    vending_fsm_multi_if.slave bus
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [PRICE_W:0]   MAX_SUM = (PRICE_W + 1)'(MAX_CREDIT);
    localparam logic [PRICE_W-1:0] TEN     = PRICE_W'(10);
    localparam logic [PRICE_W-1:0] FIVE    = PRICE_W'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]   vend_item_q, vend_item_d;
    logic               change_valid_q, change_valid_d;
    logic [1:0]         change_coin_q, change_coin_d;
    logic               coin_reject_q, coin_reject_d;
    logic               insufficient_q, insufficient_d;
    logic               busy_q, busy_d;

    logic [PRICE_W:0]   coin_val;
    logic [PRICE_W:0]   credit_sum;
    logic               coin_fits;
    logic [PRICE_W-1:0] price_sel;
    logic               sel_ok;
    logic               can_afford;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_hit;
    logic               coin_acc;

    // Coin face value
    always_comb begin
        case (bus.coin)
            2'b01:   coin_val = (PRICE_W + 1)'(5);
            2'b10:   coin_val = (PRICE_W + 1)'(10);
            2'b11:   coin_val = (PRICE_W + 1)'(20);
            default: coin_val = '0;
        endcase
    end

    assign credit_sum = {1'b0, credit_q} + coin_val;
    assign coin_fits  = (bus.coin != 2'b00) && (credit_sum <= MAX_SUM);

    // Price of the selected item; an index beyond the table is never affordable
    always_comb begin
        price_sel = '1;
        sel_ok    = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                price_sel = ITEM_PRICES[i*PRICE_W +: PRICE_W];
                sel_ok    = 1'b1;
            end
        end
    end

    assign can_afford = sel_ok && (credit_q >= price_sel);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign cnt_hit    = (cnt_inc == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        cnt_d          = '0;
        vend_item_d    = vend_item_q;
        vend_valid_d   = 1'b0;
        change_valid_d = 1'b0;
        change_coin_d  = '0;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        coin_acc       = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel && (state_q == S_CREDIT)) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    if (can_afford) begin
                        credit_d     = credit_q - price_sel;
                        vend_valid_d = 1'b1;
                        vend_item_d  = bus.sel;
                        state_d      = S_VEND;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_fits) begin
                        credit_d = credit_sum[PRICE_W-1:0];
                        state_d  = S_CREDIT;
                        coin_acc = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                // Timeout runs on every CREDIT cycle that neither accepts a
                // coin nor leaves the state, including refused requests.
                if ((state_q == S_CREDIT) && (state_d == S_CREDIT) && !coin_acc) begin
                    if (cnt_hit) begin
                        state_d = S_CHANGE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = bus.coin_valid;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (credit_q >= TEN) begin
                    credit_d       = credit_q - TEN;
                    change_valid_d = 1'b1;
                    change_coin_d  = 2'b10;
                end else if (credit_q >= FIVE) begin
                    credit_d       = credit_q - FIVE;
                    change_valid_d = 1'b1;
                    change_coin_d  = 2'b01;
                end else begin
                    credit_d = '0;
                end
                if (credit_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            cnt_q          <= '0;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_item    = vend_item_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_coin  = change_coin_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vending_fsm_multi.sv
// Testbench for vending_fsm_multi: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level machine model.
module tb_vending_fsm_multi;
    localparam int TO         = 40;
    localparam int MAX_CREDIT = 50;

    logic clk = 1'b0;
    logic rst;

    vending_fsm_multi_if #(.N_ITEMS(4), .PRICE_W(8)) bus ();

    vending_fsm_multi #(
        .N_ITEMS(4),
        .PRICE_W(8),
        .ITEM_PRICES({8'd20, 8'd15, 8'd10, 8'd5}),
        .MAX_CREDIT(MAX_CREDIT),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int price_tab[4] = '{5, 10, 15, 20};

    // Model: money held, whether a dispense or a payout is in progress,
    // and how long the customer has been inactive.
    int m_credit;
    int m_quiet;
    bit m_vending;
    bit m_refunding;
    int e_vv, e_item, e_cv, e_cc, e_rej, e_ins, e_busy;

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 20;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_quiet = 0; m_vending = 0; m_refunding = 0;
        e_vv = 0; e_item = 0; e_cv = 0; e_cc = 0; e_rej = 0; e_ins = 0; e_busy = 0;
    endtask

    task automatic model_cycle(input bit cv, input logic [1:0] cn, input bit sv,
                               input logic [1:0] s, input bit cl);
        int v;
        bit in_credit;
        bit tick;
        e_vv = 0; e_cv = 0; e_cc = 0; e_rej = 0; e_ins = 0; tick = 0;
        in_credit = (m_credit > 0) && !m_vending && !m_refunding;
        if (m_vending) begin
            e_rej = cv;
            m_vending = 0;
            m_refunding = (m_credit > 0);
        end else if (m_refunding) begin
            e_rej = cv;
            v = (m_credit >= 10) ? 10 : 5;
            m_credit -= v;
            e_cv = 1;
            e_cc = (v == 10) ? 2 : 1;
            if (m_credit == 0) m_refunding = 0;
        end else if (cl && in_credit) begin
            e_rej = cv;
            m_refunding = 1;
            m_quiet = 0;
        end else if (sv) begin
            e_rej = cv;
            if (m_credit >= price_tab[s]) begin
                m_credit -= price_tab[s];
                e_vv = 1;
                e_item = int'(s);
                m_vending = 1;
                m_quiet = 0;
            end else begin
                e_ins = 1;
                tick = 1;
            end
        end else if (cv) begin
            v = coin_value(cn);
            if (v != 0 && m_credit + v <= MAX_CREDIT) begin
                m_credit += v;
                m_quiet = 0;
            end else begin
                e_rej = 1;
                tick = 1;
            end
        end else begin
            tick = 1;
        end
        if (tick && in_credit) begin
            m_quiet++;
            if (m_quiet == TO) begin
                m_refunding = 1;
                m_quiet = 0;
            end
        end
        e_busy = (m_vending || m_refunding) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag, input bit force_item);
        chk({tag, ".credit"}, 32'(bus.credit), m_credit);
        chk({tag, ".vend_valid"}, 32'(bus.vend_valid), e_vv);
        if (e_vv != 0 || force_item) chk({tag, ".vend_item"}, 32'(bus.vend_item), e_item);
        chk({tag, ".change_valid"}, 32'(bus.change_valid), e_cv);
        chk({tag, ".change_coin"}, 32'(bus.change_coin), e_cc);
        chk({tag, ".coin_reject"}, 32'(bus.coin_reject), e_rej);
        chk({tag, ".insufficient"}, 32'(bus.insufficient), e_ins);
        chk({tag, ".busy"}, 32'(bus.busy), e_busy);
    endtask

    // Called at posedge+1: drive inputs, predict, check after the next edge.
    task automatic step(input bit cv, input logic [1:0] cn, input bit sv,
                        input logic [1:0] s, input bit cl, input string tag);
        bus.coin_valid = cv;
        bus.coin       = cn;
        bus.sel_valid  = sv;
        bus.sel        = s;
        bus.cancel     = cl;
        model_cycle(cv, cn, sv, s, cl);
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b0);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 2'd0, 0, tag);
    endtask

    // Asynchronous reset mid-cycle, held across edges with random inputs.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"}, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bus.coin_valid = 1'($urandom_range(0, 1));
            bus.coin       = 2'($urandom_range(0, 3));
            bus.sel_valid  = 1'($urandom_range(0, 1));
            bus.sel        = 2'($urandom_range(0, 3));
            bus.cancel     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_outputs({tag, ".held"}, 1'b1);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.coin_valid = 1'b0;
        bus.coin       = 2'b00;
        bus.sel_valid  = 1'b0;
        bus.sel        = '0;
        bus.cancel     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset", 1'b1);
        @(posedge clk);
        #1;
        check_outputs("reset2", 1'b1);
        rst = 1'b0;

        // 10 + 10, buy item 1 (10), one 10 rupee coin back
        step(1, 2'b10, 0, 2'd0, 0, "s34_coin");
        step(1, 2'b10, 0, 2'd0, 0, "s34_coin");
        step(0, 2'b00, 1, 2'd1, 0, "s34_sel");
        idle(4, "s34_after");

        // 20 + 5, buy item 2 (15), one 10 rupee coin back
        step(1, 2'b11, 0, 2'd0, 0, "s35_coin");
        step(1, 2'b01, 0, 2'd0, 0, "s35_coin");
        step(0, 2'b00, 1, 2'd2, 0, "s35_sel");
        idle(4, "s35_after");

        // Fill to ceiling, overflow coin and invalid coin rejected, refund
        step(1, 2'b11, 0, 2'd0, 0, "s36_coin");
        step(1, 2'b11, 0, 2'd0, 0, "s36_coin");
        step(1, 2'b10, 0, 2'd0, 0, "s36_coin");
        step(1, 2'b01, 0, 2'd0, 0, "s36_over");
        step(1, 2'b00, 0, 2'd0, 0, "s36_bad");
        step(0, 2'b00, 0, 2'd0, 1, "s36_cancel");
        idle(7, "s36_refund");

        // Cancel beats selection and coin at 15 credit
        step(1, 2'b10, 0, 2'd0, 0, "s37_coin");
        step(1, 2'b01, 0, 2'd0, 0, "s37_coin");
        step(1, 2'b01, 1, 2'd0, 1, "s37_cancel");
        idle(4, "s37_refund");

        // Low credit selection, then timeout refund
        step(1, 2'b01, 0, 2'd0, 0, "s38_coin");
        step(0, 2'b00, 1, 2'd3, 0, "s38_sel");
        idle(TO + 3, "s38_wait");

        // Reset while paying out 20
        step(1, 2'b11, 0, 2'd0, 0, "s39_coin");
        step(0, 2'b00, 0, 2'd0, 1, "s39_cancel");
        async_reset("s39_rst");
        idle(4, "s39_after");

        // Random traffic with occasional long pauses and resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle(TO + 5, "rnd_pause");
            end else if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step(1'($urandom_range(0, 99) < 30), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 99) < 15), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 99) < 4), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
